// File: rtl/pic_init_sequencer.sv
// Boot-time PIC initialiser: writes ICW1, ICW2, ICW4 and OCW1 over the PIC port.
// Once the sequence is done, the CPU port is passed straight through to the PIC.
module pic_init_sequencer #(
    parameter logic [7:0] VECTOR_BASE = 8'h08,
    parameter logic [7:0] INIT_MASK   = 8'h00,
    parameter int         ACK_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        reinit,
    input  logic        cpu_cs,
    input  logic        cpu_addr,
    input  logic [15:0] cpu_data_in,
    input  logic        cpu_wr_en,
    input  logic        cpu_access,
    output logic [15:0] cpu_data_out,
    output logic        cpu_ack,
    output logic        pic_cs,
    output logic        pic_addr,
    output logic [15:0] pic_data_out,
    output logic        pic_wr_en,
    output logic        pic_access,
    input  logic [15:0] pic_data_in,
    input  logic        pic_ack,
    output logic        init_done,
    output logic        init_error
);

    localparam int CNT_W = (ACK_TIMEOUT < 1) ? 1 : $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE_RST,
        DRIVE,
        GAP,
        DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [1:0]       r_step;
    logic [1:0]       w_step_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_pending;
    logic             w_pending_next;
    logic             r_error;
    logic             w_error_next;
    logic             w_step_addr;
    logic [15:0]      w_step_data;
    logic             w_timeout;

    always_comb begin
        w_step_addr = 1'b1;
        w_step_data = 16'h0000;
        case (r_step)
            2'd0: begin
                w_step_addr = 1'b0;
                w_step_data = 16'h0013;
            end
            2'd1: w_step_data = {8'h00, VECTOR_BASE};
            2'd2: w_step_data = 16'h0001;
            default: w_step_data = {8'h00, INIT_MASK};
        endcase
    end

    // True on the ACK_TIMEOUT-th DRIVE cycle of the current write.
    assign w_timeout = (int'(r_cnt) + 1) >= ACK_TIMEOUT;

    always_comb begin
        w_state_next   = r_state;
        w_step_next    = r_step;
        w_cnt_next     = r_cnt;
        w_pending_next = r_pending;
        w_error_next   = r_error;
        pic_cs         = 1'b0;
        pic_addr       = 1'b0;
        pic_data_out   = 16'h0000;
        pic_wr_en      = 1'b0;
        pic_access     = 1'b0;
        cpu_ack        = 1'b0;
        cpu_data_out   = 16'h0000;
        init_done      = 1'b0;
        case (r_state)
            IDLE_RST: begin
                w_state_next   = DRIVE;
                w_step_next    = 2'd0;
                w_cnt_next     = '0;
                w_pending_next = 1'b0;
            end
            DRIVE: begin
                pic_cs       = 1'b1;
                pic_access   = 1'b1;
                pic_wr_en    = 1'b1;
                pic_addr     = w_step_addr;
                pic_data_out = w_step_data;
                w_cnt_next   = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
                if (pic_ack) begin
                    w_state_next = GAP;
                end else if (w_timeout) begin
                    // Jumping to the last step makes GAP fall through to DONE.
                    w_state_next = GAP;
                    w_step_next  = 2'd3;
                    w_error_next = 1'b1;
                end
            end
            GAP: begin
                if (r_step == 2'd3) begin
                    w_state_next = DONE;
                end else begin
                    w_state_next = DRIVE;
                    w_step_next  = r_step + 2'd1;
                    w_cnt_next   = '0;
                end
            end
            DONE: begin
                init_done    = 1'b1;
                pic_cs       = cpu_cs;
                pic_addr     = cpu_addr;
                pic_data_out = cpu_data_in;
                pic_wr_en    = cpu_wr_en;
                pic_access   = cpu_access;
                cpu_ack      = pic_ack;
                cpu_data_out = pic_data_in;
                // A reinit never cuts a CPU access short; it waits for access to drop.
                if ((reinit || r_pending) && !cpu_access) begin
                    w_state_next   = IDLE_RST;
                    w_pending_next = 1'b0;
                end else if (reinit) begin
                    w_pending_next = 1'b1;
                end
            end
            default: w_state_next = IDLE_RST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= IDLE_RST;
            r_step    <= 2'd0;
            r_cnt     <= '0;
            r_pending <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_step    <= w_step_next;
            r_cnt     <= w_cnt_next;
            r_pending <= w_pending_next;
            r_error   <= w_error_next;
        end
    end

    assign init_error = r_error;

endmodule

// File: tb/tb_pic_init_sequencer.sv
// Scoreboard bench for pic_init_sequencer: expected PIC writes and CPU acks are
// queued at issue time and checked by an independent monitor.
module tb_pic_init_sequencer;

    localparam logic [7:0] VB = 8'h08;
    localparam logic [7:0] IM = 8'h00;
    localparam int         AT = 15;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        reinit = 1'b0;
    logic        cpu_cs = 1'b0;
    logic        cpu_addr = 1'b0;
    logic [15:0] cpu_data_in = 16'h0000;
    logic        cpu_wr_en = 1'b0;
    logic        cpu_access = 1'b0;
    logic [15:0] cpu_data_out;
    logic        cpu_ack;
    logic        pic_cs;
    logic        pic_addr;
    logic [15:0] pic_data_out;
    logic        pic_wr_en;
    logic        pic_access;
    logic [15:0] pic_data_in = 16'h0000;
    logic        pic_ack = 1'b0;
    logic        init_done;
    logic        init_error;

    always #5 clk = ~clk;

    pic_init_sequencer #(
        .VECTOR_BASE(VB),
        .INIT_MASK  (IM),
        .ACK_TIMEOUT(AT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .reinit      (reinit),
        .cpu_cs      (cpu_cs),
        .cpu_addr    (cpu_addr),
        .cpu_data_in (cpu_data_in),
        .cpu_wr_en   (cpu_wr_en),
        .cpu_access  (cpu_access),
        .cpu_data_out(cpu_data_out),
        .cpu_ack     (cpu_ack),
        .pic_cs      (pic_cs),
        .pic_addr    (pic_addr),
        .pic_data_out(pic_data_out),
        .pic_wr_en   (pic_wr_en),
        .pic_access  (pic_access),
        .pic_data_in (pic_data_in),
        .pic_ack     (pic_ack),
        .init_done   (init_done),
        .init_error  (init_error)
    );

    // Model PIC: two registers, ack registered one cycle after access.
    logic [15:0] pic_mem [2];
    logic        nack_icw2 = 1'b0;
    initial begin
        pic_mem[0] = 16'h0000;
        pic_mem[1] = 16'h0000;
    end
    always @(posedge clk) begin
        pic_ack <= pic_access && pic_cs &&
                   !(nack_icw2 && !init_done && pic_addr && pic_data_out == {8'h00, VB});
        if (pic_access && pic_cs && pic_wr_en) pic_mem[pic_addr] <= pic_data_out;
        if (pic_access && pic_cs && !pic_wr_en) pic_data_in <= pic_mem[pic_addr];
        else pic_data_in <= 16'($urandom);
    end

    typedef struct {
        logic        addr;
        logic [15:0] data;
        logic        wr;
        int          len;
        int          gap;
    } wr_t;

    wr_t         exp_q[$];
    logic [16:0] ack_q[$];
    logic [15:0] ref_regs [2];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic        mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    task automatic push_step(input logic addr, input logic [15:0] data, input int len, input int gap);
        wr_t e;
        e.addr = addr;
        e.data = data;
        e.wr   = 1'b1;
        e.len  = len;
        e.gap  = gap;
        exp_q.push_back(e);
    endtask

    // The full init sequence as the PIC should see it, and the register state it leaves.
    task automatic push_init(input int first_gap);
        push_step(1'b0, 16'h0013, 2, first_gap);
        push_step(1'b1, {8'h00, VB}, 2, 1);
        push_step(1'b1, 16'h0001, 2, 1);
        push_step(1'b1, {8'h00, IM}, 2, 1);
        ref_regs[0] = 16'h0013;
        ref_regs[1] = {8'h00, IM};
    endtask

    task automatic cpu_xfer(input logic addr, input logic wr, input logic [15:0] data,
                            input logic pulse_reinit);
        wr_t  e;
        logic got;
        e.addr = addr;
        e.data = data;
        e.wr   = wr;
        e.len  = 0;
        e.gap  = 0;
        exp_q.push_back(e);
        ack_q.push_back({!wr, ref_regs[addr]});
        if (wr) ref_regs[addr] = data;
        @(negedge clk);
        cpu_cs      = 1'b1;
        cpu_addr    = addr;
        cpu_data_in = data;
        cpu_wr_en   = wr;
        cpu_access  = 1'b1;
        reinit      = pulse_reinit;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            reinit = 1'b0;
            got = cpu_ack;
        end
        if (!got) fail_now("cpu_ack_timeout");
        cpu_access = 1'b0;
        cpu_cs     = 1'b0;
        cpu_wr_en  = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(posedge clk);
            #1;
            seen = init_done;
        end
        if (!seen) fail_now("init_done_timeout");
    endtask

    // Monitor: PIC-side write ordering/lengths/gaps and CPU-side acks.
    int   hi_len = 0;
    int   lo_len = 0;
    logic prev_acc = 1'b0;
    logic cur_valid = 1'b0;
    wr_t  cur;
    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            if (pic_access && !prev_acc) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_pic_access");
                    cur_valid = 1'b0;
                end else begin
                    cur = exp_q.pop_front();
                    cur_valid = 1'b1;
                    check("wr_addr", 32'(pic_addr), 32'(cur.addr));
                    check("wr_data", 32'(pic_data_out), 32'(cur.data));
                    check("wr_en", 32'(pic_wr_en), 32'(cur.wr));
                    check("wr_cs", 32'(pic_cs), 32'd1);
                    if (cur.gap != 0) check("gap_len", 32'(lo_len), 32'(cur.gap));
                end
                hi_len = 1;
            end else if (pic_access) begin
                hi_len++;
            end else if (prev_acc) begin
                if (cur_valid && cur.len != 0) check("access_len", 32'(hi_len), 32'(cur.len));
                lo_len = 1;
            end else begin
                lo_len++;
            end
            prev_acc = pic_access;
            if (!init_done) begin
                check("stall_outputs", {15'h0, cpu_ack, cpu_data_out}, 32'h0);
            end else if (cpu_ack) begin
                if (ack_q.size() == 0) begin
                    fail_now("unexpected_cpu_ack");
                end else begin
                    logic [16:0] a;
                    a = ack_q.pop_front();
                    if (a[16]) check("rd_data", 32'(cpu_data_out), 32'(a[15:0]));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        logic found;

        // Reset state
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        check("rst_init_done", 32'(init_done), 32'd0);
        check("rst_init_error", 32'(init_error), 32'd0);
        check("rst_pic_outs", {14'h0, pic_cs, pic_addr, pic_data_out}, 32'h0);
        check("rst_pic_strobes", {30'h0, pic_wr_en, pic_access}, 32'h0);
        check("rst_cpu_outs", {15'h0, cpu_ack, cpu_data_out}, 32'h0);
        mon_en = 1'b1;

        // Normal init with a CPU read issued during it
        push_init(0);
        @(negedge clk);
        reset_n = 1'b1;
        fork
            cpu_xfer(1'b1, 1'b0, 16'($urandom), 1'b0);
            begin
                found = 1'b0;
                t0 = 0;
                for (int i = 0; i < 20 && !found; i++) begin
                    @(posedge clk);
                    #1;
                    found = pic_access;
                    t0 = cyc;
                end
                if (!found) fail_now("first_write_timeout");
                wait_done(100);
                check("done_latency", 32'(cyc - t0), 32'd12);
                check("done_no_error", 32'(init_error), 32'd0);
            end
        join

        // Random CPU traffic through the pass-through port
        for (int n = 0; n < 24; n++) begin
            cpu_xfer(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom), 1'b0);
        end

        // reinit while a CPU write is in flight
        cpu_xfer(1'($urandom_range(0, 1)), 1'b1, 16'($urandom), 1'b1);
        push_init(0);
        @(posedge clk);
        #1;
        check("reinit_idle_done", 32'(init_done), 32'd0);
        check("reinit_idle_access", 32'(pic_access), 32'd0);
        @(posedge clk);
        #1;
        check("reinit_drive_access", 32'(pic_access), 32'd1);
        // reinit during the sequence must be ignored
        repeat (3) @(negedge clk);
        reinit = 1'b1;
        @(negedge clk);
        reinit = 1'b0;
        wait_done(100);
        repeat (3) @(posedge clk);
        #1;
        check("reinit_ignored_q", 32'(exp_q.size()), 32'd0);
        check("reinit_ignored_done", 32'(init_done), 32'd1);
        cpu_xfer(1'b0, 1'b0, 16'h0, 1'b0);

        // ICW2 never acked: timeout
        @(negedge clk);
        reset_n = 1'b0;
        nack_icw2 = 1'b1;
        @(negedge clk);
        push_step(1'b0, 16'h0013, 2, 0);
        push_step(1'b1, {8'h00, VB}, AT, 1);
        reset_n = 1'b1;
        wait_done(200);
        check("timeout_error", 32'(init_error), 32'd1);
        check("timeout_done", 32'(init_done), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        check("timeout_no_more_writes", 32'(exp_q.size()), 32'd0);

        // Plain reinit: error stays sticky
        nack_icw2 = 1'b0;
        push_init(0);
        @(negedge clk);
        reinit = 1'b1;
        @(negedge clk);
        reinit = 1'b0;
        #1;
        check("reinit_plain_done", 32'(init_done), 32'd0);
        wait_done(100);
        check("error_sticky", 32'(init_error), 32'd1);

        // Reset during the ICW4 write
        push_step(1'b0, 16'h0013, 2, 0);
        push_step(1'b1, {8'h00, VB}, 2, 1);
        push_step(1'b1, 16'h0001, 0, 1);
        @(negedge clk);
        reinit = 1'b1;
        @(negedge clk);
        reinit = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(posedge clk);
            #1;
            found = pic_access && pic_addr && (pic_data_out == 16'h0001) && !init_done;
        end
        if (!found) fail_now("icw4_wait_timeout");
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort_access", 32'(pic_access), 32'd0);
        check("abort_error_cleared", 32'(init_error), 32'd0);
        push_init(0);
        @(negedge clk);
        reset_n = 1'b1;
        wait_done(100);
        check("restart_no_error", 32'(init_error), 32'd0);
        cpu_xfer(1'b0, 1'b0, 16'h0, 1'b0);
        cpu_xfer(1'b1, 1'b0, 16'h0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("final_exp_q_empty", 32'(exp_q.size()), 32'd0);
        check("final_ack_q_empty", 32'(ack_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pic_init_sequencer.md
PIC_INIT_SEQUENCER -- requirements
Module: pic_init_sequencer

Interface
REQ-001 SHALL have parameter VECTOR_BASE, default 8'h08, meaning the ICW2 value (vector base, bits [2:0] ignored by the PIC).
REQ-002 SHALL have parameter INIT_MASK, default 8'h00, meaning the OCW1 interrupt mask written at the end of initialisation.
REQ-003 SHALL have parameter ACK_TIMEOUT, default 15, meaning the maximum cycles waited for pic_ack per write.
REQ-004 SHALL have ports, clock and reset first:
 clk  in  1  single clock, all logic on the rising edge
 reset_n  in  1  synchronous, active-low reset
 reinit  in  1  single-cycle request to rerun the init sequence
 cpu_cs  in  1  CPU selects the PIC
 cpu_addr  in  1  CPU register select (0 = command, 1 = data)
 cpu_data_in  in  16  CPU write data
 cpu_wr_en  in  1  CPU write strobe
 cpu_access  in  1  CPU access request
 cpu_data_out  out  16  read data returned to the CPU
 cpu_ack  out  1  access acknowledge to the CPU
 pic_cs  out  1  PIC chip select
 pic_addr  out  1  PIC register select
 pic_data_out  out  16  write data to the PIC
 pic_wr_en  out  1  PIC write strobe
 pic_access  out  1  PIC access request
 pic_data_in  in  16  PIC read data
 pic_ack  in  1  PIC acknowledge, registered one cycle after access
 init_done  out  1  high while the sequence is complete and the CPU owns the PIC port
 init_error  out  1  sticky, set when any init write times out

Function
REQ-005 SHALL implement FSM states IDLE_RST, DRIVE, GAP and DONE, plus a 2-bit step index (0 = ICW1, 1 = ICW2, 2 = ICW4, 3 = OCW1).
REQ-006 SHALL use the following step values: ICW1 = addr 0, data 16'h0013; ICW2 = addr 1, data {8'h00, VECTOR_BASE}; ICW4 = addr 1, data 16'h0001; OCW1 = addr 1, data {8'h00, INIT_MASK}.
REQ-007 In IDLE_RST, SHALL drive all pic_* outputs to 0 and go to DRIVE with step 0 on the next cycle.
REQ-008 In DRIVE, SHALL drive pic_cs = 1, pic_access = 1 and pic_wr_en = 1, with pic_addr and pic_data_out from the current step; it SHALL hold these until pic_ack = 1 is sampled, then go to GAP.
REQ-009 In GAP, SHALL deassert all pic_* outputs for exactly 1 cycle so that a stale pic_ack is never taken as the next ack; it SHALL then go to DRIVE with step+1, or to DONE if step = 3.
REQ-010 SHALL keep a timeout counter that clears on entry to DRIVE and increments each DRIVE cycle; when it reaches ACK_TIMEOUT without an ack, SHALL set init_error, abandon the remaining steps and go to GAP then DONE.
REQ-011 The counter SHALL be wide enough for ACK_TIMEOUT and SHALL saturate, never wrap.
REQ-012 Outside DONE, SHALL hold cpu_ack = 0 and cpu_data_out = 0 and ignore CPU requests, so the CPU stalls.
REQ-013 In DONE, SHALL pass the cpu_* inputs combinationally to the matching pic_* outputs and pass pic_ack/pic_data_in to cpu_ack/cpu_data_out, with zero added latency.
REQ-014 SHALL drive init_done = 1 only in DONE.
REQ-015 When reinit = 1 in DONE with cpu_access = 0, SHALL go to IDLE_RST on the next cycle.
REQ-016 When reinit = 1 in DONE with cpu_access = 1, SHALL latch a pending request and act on it in the first cycle where cpu_access = 0; the in-flight CPU access SHALL complete untouched.
REQ-017 SHALL ignore reinit outside DONE, with no queuing.
REQ-018 SHALL clear init_error only on reset, not on reinit.

Reset
REQ-019 SHALL, while reset_n = 0 at a clock edge, enter IDLE_RST with step = 0, counter = 0, pending reinit cleared, init_error = 0, init_done = 0, all pic_* = 0, cpu_ack = 0 and cpu_data_out = 0.
REQ-020 A reset asserted mid-write SHALL abort the write immediately; the sequence SHALL restart from ICW1 after release.

Verification
REQ-021 Release reset with a model PIC (ack 1 cycle after access) -> writes in order: (0, 16'h0013), (1, 16'h0008), (1, 16'h0001), (1, 16'h0000); each write is 2 cycles with access high and is followed by a 1-cycle gap; init_done rises 12 cycles after release.
REQ-022 CPU read of addr 1 issued during init -> cpu_ack stays 0 until init_done; after that the read completes, with cpu_data_out equal to pic_data_in on the ack cycle.
REQ-023 Model PIC never acks ICW2 -> init_error = 1 after ACK_TIMEOUT DRIVE cycles, no ICW4 or OCW1 writes, init_done = 1.
REQ-024 reinit pulsed in DONE while cpu_access = 1 -> CPU access acked normally, sequence restarts the cycle after cpu_access falls, and the ICW1 write reappears.
REQ-025 reset_n low during the ICW4 DRIVE state -> pic_access = 0 on the next cycle; after release the first write is ICW1 again.
